nco_fcw_estimator: RTL and testbench
====================================

Name: nco_fcw_estimator

Overview:
- Receiver-side counterpart of the team's phase-accumulator NCO.
- Observes a stream of NCO phase samples and recovers the frequency control word (FCW) that produced them.
- Computes the wrap-aware phase increment per sample and averages it over a fixed window.
- Declares lock when successive window estimates agree; used for NCO self-test and for loop-back frequency checks.

Parameters:
- NCO_BITS, 10, width of the observed phase word.
- NCO_FREQ_BITS, 4, width of the recovered FCW; the legal increment range is 0..2^NCO_FREQ_BITS-1.
- AVG_LOG2, 3, log2 of the number of increments averaged per window (8 by default); must be at least 0.
- LOCK_COUNT, 4, number of consecutive identical window results required to assert lock; must be at least 2.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, asynchronous, active-high
- phase_in  input  NCO_BITS  observed NCO phase sample
- phase_valid_in  input  1  phase_in is a new sample this cycle
- fcw_out  output  NCO_FREQ_BITS  last completed window estimate
- fcw_valid_out  output  1  one-cycle pulse when fcw_out updates
- locked_out  output  1  estimate stable for LOCK_COUNT windows
- range_err_out  output  1  one-cycle pulse when an increment exceeds the FCW range

Behaviour:
- Reset: clk_in is the clock; rst_in is asynchronous, active-high. While reset is asserted: all outputs are 0, the state is PRIME, and the accumulator, sample counter, stored previous sample, streak counter and last result are all 0.
- All outputs are registered. There are no combinational paths from input to output.
- When phase_valid_in=0, no internal state changes and the pulse outputs are driven low. Gaps of any length between samples are legal.
- State PRIME: the first valid sample is stored as prev. No increment is computed. Next state is ACQ.
- States ACQ and LOCKED, on each valid sample:
  - delta = (phase_in - prev) mod 2^NCO_BITS, computed as an NCO_BITS-wide unsigned subtraction so wrap-around is inherent.
  - phase_in becomes the new prev.
- Range check: if delta > 2^NCO_FREQ_BITS-1, then on that edge:
  - range_err_out pulses high.
  - The accumulator and sample counter clear; the partial window is discarded.
  - The streak counter clears and locked_out drops to 0.
  - State becomes ACQ. prev is still updated.
- Otherwise, delta is added into an accumulator of width NCO_FREQ_BITS+AVG_LOG2, and the sample counter (AVG_LOG2+1 bits) increments.
- Window completion: on the edge that accepts the 2^AVG_LOG2-th in-range delta:
  - fcw_out <= (accumulator + delta) >> AVG_LOG2, truncated (floor).
  - fcw_valid_out pulses for one cycle.
  - The accumulator and counter clear for the next window. Windows are back-to-back with no lost sample.
- Latency: fcw_out and fcw_valid_out are visible in the cycle after the rising edge that samples the final delta of a window.
- Lock logic, evaluated at window completion:
  - If the new result equals the previous window's result, the streak increments, saturating at LOCK_COUNT-1. Otherwise the streak resets to 0.
  - When the streak reaches LOCK_COUNT-1 (LOCK_COUNT equal results in a row), state becomes LOCKED and locked_out=1.
  - In LOCKED, a differing result drops locked_out and returns the state to ACQ with streak 0.
  - The first window after reset or after a range error has no previous result; it starts the streak at 0.
- fcw_out holds its value until the next window completes. It is not cleared by a range error.
- Zero FCW (constant phase): delta=0 is legal. The block yields fcw_out=0 and can lock.
- Reset mid-window or mid-lock: the block returns immediately to PRIME with every output 0. The next valid sample re-primes.

Decomposition:
- Shared package nco_pkg holds:
  - default NCO_BITS and NCO_FREQ_BITS constants, shared with the NCO generator;
  - the state enum {PRIME, ACQ, LOCKED}.
- One natural sub-module, nco_phase_delta: it holds the prev register, the modular subtractor and the range comparator. It outputs delta, delta_valid and delta_err. Its internal register does not add latency to the top-level timing above.

Test Plan:
- NCO_BITS=10, NCO_FREQ_BITS=4, AVG_LOG2=3. Phases 0,5,10,...,40 with valid every cycle -> after the 9th sample, fcw_out=5 and fcw_valid_out pulses once; continue the stream -> locked_out=1 after the 4th consecutive window.
- Wrap-around: phases 1015,1020,1,6,... (FCW 5) -> no range_err; fcw_out=5; lock is reached as in the previous test.
- Alternating deltas 3,4 -> window sum 28, fcw_out=3 each window; locked after 4 windows. Then switch to FCW 7 -> next result 7, locked_out drops the same edge, relocks after 4 windows of 7.
- While locked at FCW 5, inject a phase jump of +20 -> range_err_out pulses one cycle, locked_out=0, fcw_out stays 5; the next full window yields 5 again.
- Irregular phase_valid_in (valid 1 cycle in 3) with FCW 2 -> results identical to the continuous case; no pulses occur on invalid cycles.
- Assert rst_in asynchronously mid-window while locked -> all outputs 0 immediately; after release, the first valid sample only primes and the first fcw_valid_out comes 8 in-range deltas later.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared NCO definitions: default phase/FCW widths (common with the NCO generator)
// and the estimator state encoding.
package nco_pkg;

  localparam int NCO_BITS_DEF      = 10;
  localparam int NCO_FREQ_BITS_DEF = 4;

  typedef enum logic [1:0] {
    PRIME  = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/nco_phase_delta.sv
// Wrap-aware phase increment: holds the previous sample and presents the modular
// difference and range flag combinationally against the current sample.
module nco_phase_delta
  import nco_pkg::*;
#(
  parameter int NCO_BITS      = NCO_BITS_DEF,
  parameter int NCO_FREQ_BITS = NCO_FREQ_BITS_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NCO_BITS-1:0]      i_phase,
  input  logic                     i_valid,
  input  logic                     i_prime,
  output logic [NCO_FREQ_BITS-1:0] o_delta,
  output logic                     o_delta_valid,
  output logic                     o_delta_err
);

  localparam logic [NCO_BITS-1:0] MAX_INC = NCO_BITS'((1 << NCO_FREQ_BITS) - 1);

  logic [NCO_BITS-1:0] r_prev;
  logic [NCO_BITS-1:0] w_delta;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)       r_prev <= '0;
    else if (i_valid) r_prev <= i_phase;
  end

  // Unsigned subtraction at phase width makes wrap-around inherent.
  assign w_delta       = i_phase - r_prev;
  assign o_delta       = w_delta[NCO_FREQ_BITS-1:0];
  assign o_delta_valid = i_valid & ~i_prime;
  assign o_delta_err   = o_delta_valid & (w_delta > MAX_INC);

endmodule

// File: rtl/nco_fcw_estimator.sv
// Recovers an NCO frequency control word from observed phase samples by
// averaging per-sample increments over fixed windows, and flags lock on agreement.
module nco_fcw_estimator
  import nco_pkg::*;
#(
  parameter int NCO_BITS      = NCO_BITS_DEF,
  parameter int NCO_FREQ_BITS = NCO_FREQ_BITS_DEF,
  parameter int AVG_LOG2      = 3,
  parameter int LOCK_COUNT    = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NCO_BITS-1:0]      phase_in,
  input  logic                     phase_valid_in,
  output logic [NCO_FREQ_BITS-1:0] fcw_out,
  output logic                     fcw_valid_out,
  output logic                     locked_out,
  output logic                     range_err_out
);

  localparam int ACC_W    = NCO_FREQ_BITS + AVG_LOG2;
  localparam int CNT_W    = AVG_LOG2 + 1;
  localparam int STREAK_W = $clog2(LOCK_COUNT);
  localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [STREAK_W-1:0] STREAK_LAST = STREAK_W'(LOCK_COUNT - 1);

  state_t                    r_state, w_state_nxt;
  logic [ACC_W-1:0]          r_acc, w_acc_nxt, w_sum;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic [STREAK_W-1:0]       r_streak, w_streak_nxt;
  logic                      r_have_last, w_have_last_nxt;
  logic [NCO_FREQ_BITS-1:0]  r_fcw, w_fcw_nxt, w_result;
  logic                      r_fcw_valid, w_fcw_valid_nxt;
  logic                      r_locked, w_locked_nxt;
  logic                      r_range_err, w_range_err_nxt;

  logic [NCO_FREQ_BITS-1:0]  w_delta;
  logic                      w_delta_valid;
  logic                      w_delta_err;

  nco_phase_delta #(
    .NCO_BITS      (NCO_BITS),
    .NCO_FREQ_BITS (NCO_FREQ_BITS)
  ) u_phase_delta (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .i_phase       (phase_in),
    .i_valid       (phase_valid_in),
    .i_prime       (r_state == PRIME),
    .o_delta       (w_delta),
    .o_delta_valid (w_delta_valid),
    .o_delta_err   (w_delta_err)
  );

  assign w_sum    = r_acc + ACC_W'(w_delta);
  assign w_result = w_sum[ACC_W-1:AVG_LOG2];

  // NOTE: every signal gets its hold value first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_streak_nxt    = r_streak;
    w_have_last_nxt = r_have_last;
    w_fcw_nxt       = r_fcw;
    w_fcw_valid_nxt = 1'b0;
    w_locked_nxt    = r_locked;
    w_range_err_nxt = 1'b0;

    if (phase_valid_in && r_state == PRIME) begin
      w_state_nxt = ACQ;
    end else if (w_delta_valid && w_delta_err) begin
      // Discard the partial window and forget the previous result.
      w_range_err_nxt = 1'b1;
      w_acc_nxt       = '0;
      w_cnt_nxt       = '0;
      w_streak_nxt    = '0;
      w_have_last_nxt = 1'b0;
      w_locked_nxt    = 1'b0;
      w_state_nxt     = ACQ;
    end else if (w_delta_valid && r_cnt == CNT_LAST) begin
      w_fcw_nxt       = w_result;
      w_fcw_valid_nxt = 1'b1;
      w_acc_nxt       = '0;
      w_cnt_nxt       = '0;
      w_have_last_nxt = 1'b1;
      if (r_have_last && w_result == r_fcw)
        w_streak_nxt = (r_streak == STREAK_LAST) ? r_streak : r_streak + STREAK_W'(1);
      else
        w_streak_nxt = '0;
      if (w_streak_nxt == STREAK_LAST) begin
        w_state_nxt  = LOCKED;
        w_locked_nxt = 1'b1;
      end else begin
        w_state_nxt  = ACQ;
        w_locked_nxt = 1'b0;
      end
    end else if (w_delta_valid) begin
      w_acc_nxt = w_sum;
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= PRIME;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_streak    <= '0;
      r_have_last <= 1'b0;
      r_fcw       <= '0;
      r_fcw_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_streak    <= w_streak_nxt;
      r_have_last <= w_have_last_nxt;
      r_fcw       <= w_fcw_nxt;
      r_fcw_valid <= w_fcw_valid_nxt;
      r_locked    <= w_locked_nxt;
      r_range_err <= w_range_err_nxt;
    end
  end

  assign fcw_out       = r_fcw;
  assign fcw_valid_out = r_fcw_valid;
  assign locked_out    = r_locked;
  assign range_err_out = r_range_err;

endmodule

// File: tb/tb_nco_fcw_estimator.sv
// Directed, table-driven bench for nco_fcw_estimator: per-cycle vectors of
// {phase, valid} with hand-derived expected outputs, plus reset sequences.
module tb_nco_fcw_estimator;

  typedef struct {
    logic [9:0] phase;
    logic       valid;
    logic [3:0] exp_fcw;
    logic       exp_fv;
    logic       exp_lock;
    logic       exp_err;
  } vec_t;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [9:0] phase_in = '0;
  logic       phase_valid_in = 1'b0;
  logic [3:0] fcw_out;
  logic       fcw_valid_out;
  logic       locked_out;
  logic       range_err_out;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  nco_fcw_estimator #(
    .NCO_BITS      (10),
    .NCO_FREQ_BITS (4),
    .AVG_LOG2      (3),
    .LOCK_COUNT    (4)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .phase_in       (phase_in),
    .phase_valid_in (phase_valid_in),
    .fcw_out        (fcw_out),
    .fcw_valid_out  (fcw_valid_out),
    .locked_out     (locked_out),
    .range_err_out  (range_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int phase, input logic valid, input int fcw,
                      input logic fv, input logic lk, input logic er);
    vec_t v;
    v.phase    = 10'(phase);
    v.valid    = valid;
    v.exp_fcw  = 4'(fcw);
    v.exp_fv   = fv;
    v.exp_lock = lk;
    v.exp_err  = er;
    vecs.push_back(v);
  endtask

  // Constant-FCW stream starting right after reset; sample k=0 only primes.
  // Windows complete at k=8,16,24,32; the fourth equal window locks.
  task automatic build_const(input int start, input int step, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      int   f;
      logic lk;
      f  = (k >= 8) ? step : 0;
      lk = (k >= 32);
      push(start + step * k, 1'b1, f, (k >= 8) && (k % 8 == 0), lk, 1'b0);
      for (int g = 0; g < gap; g++)
        push(999 - g * 37, 1'b0, f, 1'b0, lk, 1'b0);
    end
  endtask

  task automatic apply_all(input string tag);
    foreach (vecs[i]) begin
      phase_in       = vecs[i].phase;
      phase_valid_in = vecs[i].valid;
      @(posedge clk_in);
      #1;
      check({tag, ".fcw"},   32'(fcw_out),       32'(vecs[i].exp_fcw));
      check({tag, ".fv"},    32'(fcw_valid_out), 32'(vecs[i].exp_fv));
      check({tag, ".lock"},  32'(locked_out),    32'(vecs[i].exp_lock));
      check({tag, ".err"},   32'(range_err_out), 32'(vecs[i].exp_err));
    end
    vecs.delete();
    phase_valid_in = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".fcw0"},  32'(fcw_out),       32'd0);
    check({tag, ".fv0"},   32'(fcw_valid_out), 32'd0);
    check({tag, ".lock0"}, 32'(locked_out),    32'd0);
    check({tag, ".err0"},  32'(range_err_out), 32'd0);
  endtask

  // Reset asserted away from any clock edge; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    #2;
    rst_in = 1'b1;
    #1;
    check_zero(tag);
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    check_zero({tag, ".rel"});
  endtask

  initial begin
    int p;

    #3;
    check_zero("init");
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;

    // FCW 5 from phase 0: result at 9th sample, lock after 4 windows.
    build_const(0, 5, 36, 0);
    apply_all("fcw5");

    // Wrap-around stream at FCW 5.
    do_reset("rst_wrap");
    build_const(1015, 5, 33, 0);
    apply_all("wrap");

    // Zero FCW: constant phase yields 0 and still locks.
    do_reset("rst_zero");
    build_const(77, 0, 33, 0);
    apply_all("zero");

    // Alternating 3,4 -> 28/8 = 3; then FCW 7 drops lock and relocks.
    do_reset("rst_alt");
    p = 40;
    push(p, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      int f;
      p += (k <= 32) ? ((k % 2 == 1) ? 3 : 4) : 7;
      f = (k < 8) ? 0 : (k < 40) ? 3 : 7;
      push(p, 1'b1, f, (k >= 8) && (k % 8 == 0), (k >= 32 && k < 40) || k >= 64, 1'b0);
    end
    apply_all("alt");

    // Locked at 5, then a +20 jump mid-window.
    do_reset("rst_jump");
    build_const(0, 5, 33, 0);
    p = 160;
    for (int k = 0; k < 3; k++) begin
      p += 5;
      push(p, 1'b1, 5, 1'b0, 1'b1, 1'b0);
    end
    p += 20;
    push(p, 1'b1, 5, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      p += 5;
      push(p, 1'b1, 5, (k == 8), 1'b0, 1'b0);
    end
    apply_all("jump");

    // Boundary: delta 15 is legal, delta 16 is a range error.
    do_reset("rst_max");
    build_const(0, 15, 9, 0);
    push(136, 1'b1, 15, 1'b0, 1'b0, 1'b1);
    push(151, 1'b1, 15, 1'b0, 1'b0, 1'b0);
    apply_all("max");

    // Irregular valid (1 in 3) at FCW 2, garbage phase on idle cycles.
    do_reset("rst_gap");
    build_const(500, 2, 33, 2);
    apply_all("gap");

    // Locked and mid-window, then async reset; re-prime with FCW 6.
    do_reset("rst_pre");
    build_const(0, 5, 36, 0);
    apply_all("prelock");
    do_reset("rst_mid");
    build_const(300, 6, 10, 0);
    apply_all("reprime");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule
